// File: rtl/dmem_arbiter_pkg.sv
// mips_dmem_pkg: shared state, requester id and counter width for the data memory arbiter
package mips_dmem_pkg;
    localparam int CNT_W = 3;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {REQ_PIPE, REQ_LOAD} req_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: pipeline, loader and memory-side signals of the data memory arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              p_read;
    logic              p_write;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic [DATA_W-1:0] p_rdata;
    logic              p_stall;
    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_gnt;
    logic              l_done;
    logic [DATA_W-1:0] l_rdata;
    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    modport slave (
        input  p_read, p_write, p_addr, p_wdata, l_req, l_we, l_addr, l_wdata, m_rdata,
        output p_rdata, p_stall, l_gnt, l_done, l_rdata, m_read, m_write, m_addr, m_wdata
    );
    modport master (
        output p_read, p_write, p_addr, p_wdata, l_req, l_we, l_addr, l_wdata, m_rdata,
        input  p_rdata, p_stall, l_gnt, l_done, l_rdata, m_read, m_write, m_addr, m_wdata
    );
endinterface

// File: rtl/dmem_arbiter_grant.sv
// dmem_grant: winner select between pipeline and loader (round robin under DMEM_ARB_ROUND_ROBIN_EN)
module dmem_grant
    import mips_dmem_pkg::*;
(
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic rst,
    input  logic take,
`endif
    input  logic p_req,
    input  logic l_req,
    output req_t win
);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    req_t last_q, last_d;
    // on a tie the requester not served last wins; flag follows every grant
    always_comb begin
        win    = (p_req && l_req) ? ((last_q == REQ_PIPE) ? REQ_LOAD : REQ_PIPE)
                                  : (l_req ? REQ_LOAD : REQ_PIPE);
        last_d = take ? win : last_q;
    end
    // last-served flag, loader after reset so the pipeline wins the first tie
    always_ff @(posedge clk) begin
        if (rst) last_q <= REQ_LOAD;
        else     last_q <= last_d;
    end
`else
    // fixed priority: loader only when the pipeline is not asking
    always_comb win = (l_req && !p_req) ? REQ_LOAD : REQ_PIPE;
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: MEM-stage / loader sequencer for single-port data memory; DMEM_ARB_ROUND_ROBIN_EN enables round-robin grant
module dmem_arbiter
    import mips_dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input logic          clk,
    input logic          rst,
    dmem_arbiter_if.slave bus
);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              win_q, win_d, sel;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
    logic [DATA_W-1:0] l_rdata_q, l_rdata_d;
    logic              p_req, any, take;

    assign p_req = bus.p_read | bus.p_write;
    assign any   = p_req | bus.l_req;
    assign take  = (state_q == IDLE) && any;

    dmem_grant u_grant (
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        .clk  (clk),
        .rst  (rst),
        .take (take),
`endif
        .p_req(p_req),
        .l_req(bus.l_req),
        .win  (sel)
    );

    // sequencing: latch the winner in IDLE, count wait states in ACCESS, capture read data on the last one
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        p_rdata_d = p_rdata_q;
        l_rdata_d = l_rdata_q;
        if (take) begin
            state_d = ACCESS;
            cnt_d   = CNT_W'(WAIT_STATES);
            win_d   = sel;
            we_d    = (sel == REQ_PIPE) ? bus.p_write : bus.l_we;
            addr_d  = (sel == REQ_PIPE) ? bus.p_addr  : bus.l_addr;
            wdata_d = (sel == REQ_PIPE) ? bus.p_wdata : bus.l_wdata;
        end else if (state_q == ACCESS) begin
            if (cnt_q == '0) begin
                state_d   = RESP;
                p_rdata_d = (win_q == REQ_PIPE) ? bus.m_rdata : p_rdata_q;
                l_rdata_d = (win_q == REQ_LOAD) ? bus.m_rdata : l_rdata_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end

    // state and access/read registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            win_q     <= REQ_PIPE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            p_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            p_rdata_q <= p_rdata_d;
            l_rdata_q <= l_rdata_d;
        end
    end

    // memory strobes come only from the access registers so they hold steady through ACCESS
    assign bus.m_read  = (state_q == ACCESS) && !we_q;
    assign bus.m_write = (state_q == ACCESS) && we_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;
    assign bus.p_rdata = p_rdata_q;
    assign bus.l_rdata = l_rdata_q;
    assign bus.p_stall = p_req && !((state_q == RESP) && (win_q == REQ_PIPE));
    assign bus.l_gnt   = !rst && take && (sel == REQ_LOAD);
    assign bus.l_done  = (state_q == RESP) && (win_q == REQ_LOAD);
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter at WAIT_STATES 0, 1 and 3
module tb_dmem_arbiter;
    logic clk, rst, poke;
    logic [31:0] poke_a, poke_d;
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    int gnt_c, done_c, low_c;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

    dmem_arbiter #(.WAIT_STATES(0)) d0 (.clk(clk), .rst(rst), .bus(b0));
    dmem_arbiter #(.WAIT_STATES(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
    dmem_arbiter #(.WAIT_STATES(3)) d3 (.clk(clk), .rst(rst), .bus(b3));

    function automatic logic [7:0] h(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
    endfunction

    assign b0.m_rdata = mem0[h(b0.m_addr)];
    assign b1.m_rdata = mem1[h(b1.m_addr)];
    assign b3.m_rdata = mem3[h(b3.m_addr)];

    always @(posedge clk) begin
        if (b0.m_write) mem0[h(b0.m_addr)] <= b0.m_wdata;
        else if (poke)  mem0[h(poke_a)] <= poke_d;
        if (b1.m_write) mem1[h(b1.m_addr)] <= b1.m_wdata;
        else if (poke)  mem1[h(poke_a)] <= poke_d;
        if (b3.m_write) mem3[h(b3.m_addr)] <= b3.m_wdata;
        else if (poke)  mem3[h(poke_a)] <= poke_d;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        {b0.p_read, b0.p_write, b0.l_req, b0.l_we} = '0;
        {b1.p_read, b1.p_write, b1.l_req, b1.l_we} = '0;
        {b3.p_read, b3.p_write, b3.l_req, b3.l_we} = '0;
        b0.p_addr = '0; b0.p_wdata = '0; b0.l_addr = '0; b0.l_wdata = '0;
        b1.p_addr = '0; b1.p_wdata = '0; b1.l_addr = '0; b1.l_wdata = '0;
        b3.p_addr = '0; b3.p_wdata = '0; b3.l_addr = '0; b3.l_wdata = '0;
        poke = 1'b0; poke_a = '0; poke_d = '0;
        rst = 1'b1;
        cyc;
        cyc;
        rst = 1'b0;
        #1;
        chk32("rst_p_rdata", b1.p_rdata, 32'h0);
        chk32("rst_l_rdata", b1.l_rdata, 32'h0);
        chk32("rst_m_addr", b1.m_addr, 32'h0);
        chk32("rst_m_wdata", b1.m_wdata, 32'h0);
        chk1("rst_p_stall", b1.p_stall, 1'b0);
        chk1("rst_l_gnt", b1.l_gnt, 1'b0);
        chk1("rst_l_done", b1.l_done, 1'b0);
        chk1("rst_m_read", b1.m_read, 1'b0);
        chk1("rst_m_write", b1.m_write, 1'b0);
        poke = 1'b1; poke_a = 32'h00230000; poke_d = 32'h002300AA;
        cyc;
        poke_a = 32'h00000020; poke_d = 32'h33333333;
        cyc;
        poke = 1'b0;

        // pipeline load, W=1
        b1.p_read = 1'b1; b1.p_addr = 32'h00230000;
        for (int c = 0; c <= 3; c++) begin
            #1;
            chk1($sformatf("ld_stall_c%0d", c), b1.p_stall, c < 3);
            chk1($sformatf("ld_m_read_c%0d", c), b1.m_read, c == 1 || c == 2);
            if (c == 1) chk32("ld_m_addr", b1.m_addr, 32'h00230000);
            if (c == 3) chk32("ld_p_rdata", b1.p_rdata, 32'h002300AA);
            if (c < 3) cyc;
        end
        b1.p_read = 1'b0;
        cyc;

        // loader write then pipeline read
        b1.l_req = 1'b1; b1.l_we = 1'b1; b1.l_addr = 32'hA42ADFB0; b1.l_wdata = 32'h8C123456;
        for (int c = 0; c <= 3; c++) begin
            #1;
            chk1($sformatf("lw_gnt_c%0d", c), b1.l_gnt, c == 0);
            chk1($sformatf("lw_done_c%0d", c), b1.l_done, c == 3);
            chk1($sformatf("lw_m_write_c%0d", c), b1.m_write, c == 1 || c == 2);
            if (c < 3) cyc;
        end
        b1.l_req = 1'b0; b1.l_we = 1'b0;
        cyc;
        b1.p_read = 1'b1; b1.p_addr = 32'hA42ADFB0;
        repeat (3) cyc;
        #1;
        chk1("lr_stall", b1.p_stall, 1'b0);
        chk32("lr_p_rdata", b1.p_rdata, 32'h8C123456);
        b1.p_read = 1'b0;
        cyc;

        // simultaneous pipeline store and loader read, from reset
        rst = 1'b1;
        cyc;
        rst = 1'b0;
        b1.p_write = 1'b1; b1.p_addr = 32'h10; b1.p_wdata = 32'h11111111;
        b1.l_req = 1'b1; b1.l_we = 1'b0; b1.l_addr = 32'h10;
        #1;
        chk1("sim_gnt_c0", b1.l_gnt, 1'b0);
        chk1("sim_stall_c0", b1.p_stall, 1'b1);
        cyc;
        #1;
        chk1("sim_m_write_c1", b1.m_write, 1'b1);
        chk32("sim_m_addr_c1", b1.m_addr, 32'h10);
        cyc;
        cyc;
        #1;
        chk1("sim_stall_c3", b1.p_stall, 1'b0);
        b1.p_addr = 32'h14; b1.p_wdata = 32'h22222222;
        cyc;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        gnt_c = 4; done_c = 7; low_c = 11;
`else
        gnt_c = 8; done_c = 11; low_c = 7;
`endif
        for (int c = 4; c <= 11; c++) begin
            #1;
            chk1($sformatf("sim_gnt_c%0d", c), b1.l_gnt, c == gnt_c);
            chk1($sformatf("sim_done_c%0d", c), b1.l_done, c == done_c);
            chk1($sformatf("sim_stall_c%0d", c), b1.p_stall, c < low_c);
            if (c == done_c) chk32("sim_l_rdata", b1.l_rdata, 32'h11111111);
            if (c == low_c) b1.p_write = 1'b0;
            if (c == done_c) b1.l_req = 1'b0;
            cyc;
        end

        // reset in the second ACCESS cycle, W=3, then the held load re-issues
        b3.p_read = 1'b1; b3.p_addr = 32'h20;
        #1;
        chk1("rw_stall_c0", b3.p_stall, 1'b1);
        cyc;
        #1;
        chk1("rw_m_read_c1", b3.m_read, 1'b1);
        cyc;
        #1;
        chk1("rw_m_read_c2", b3.m_read, 1'b1);
        rst = 1'b1;
        cyc;
        rst = 1'b0;
        #1;
        chk1("rw_m_write_c3", b3.m_write, 1'b0);
        chk1("rw_l_done_c3", b3.l_done, 1'b0);
        chk1("rw_l_gnt_c3", b3.l_gnt, 1'b0);
        for (int c = 3; c <= 8; c++) begin
            if (c > 3) #1;
            chk1($sformatf("rw_stall_c%0d", c), b3.p_stall, c < 8);
            chk1($sformatf("rw_m_read_c%0d", c), b3.m_read, c >= 4 && c <= 7);
            if (c == 8) chk32("rw_p_rdata", b3.p_rdata, 32'h33333333);
            if (c < 8) cyc;
        end
        b3.p_read = 1'b0;
        cyc;

        // W=0: four back-to-back stores, then read each back
        for (int k = 0; k < 4; k++) begin
            b0.p_write = 1'b1; b0.p_addr = 32'h40 + 32'(4 * k); b0.p_wdata = 32'hA0000000 + 32'(k);
            for (int c = 0; c <= 2; c++) begin
                #1;
                chk1($sformatf("w0_st%0d_stall_c%0d", k, c), b0.p_stall, c < 2);
                chk1($sformatf("w0_st%0d_m_write_c%0d", k, c), b0.m_write, c == 1);
                if (c < 2) cyc;
            end
            if (k == 3) b0.p_write = 1'b0;
            cyc;
        end
        for (int k = 0; k < 4; k++) begin
            b0.p_read = 1'b1; b0.p_addr = 32'h40 + 32'(4 * k);
            #1;
            chk1($sformatf("w0_ld%0d_stall_c0", k), b0.p_stall, 1'b1);
            cyc;
            cyc;
            #1;
            chk1($sformatf("w0_ld%0d_stall_c2", k), b0.p_stall, 1'b0);
            chk32($sformatf("w0_ld%0d_p_rdata", k), b0.p_rdata, 32'hA0000000 + 32'(k));
            if (k == 3) b0.p_read = 1'b0;
            cyc;
        end

        // flush: store dropped during ACCESS still commits
        b1.p_write = 1'b1; b1.p_addr = 32'h60; b1.p_wdata = 32'h5A5A5A5A;
        #1;
        chk1("fl_stall_c0", b1.p_stall, 1'b1);
        cyc;
        b1.p_write = 1'b0;
        #1;
        chk1("fl_stall_c1", b1.p_stall, 1'b0);
        chk1("fl_m_write_c1", b1.m_write, 1'b1);
        cyc;
        #1;
        chk1("fl_stall_c2", b1.p_stall, 1'b0);
        chk1("fl_m_write_c2", b1.m_write, 1'b1);
        cyc;
        #1;
        chk1("fl_stall_c3", b1.p_stall, 1'b0);
        chk1("fl_m_write_c3", b1.m_write, 1'b0);
        cyc;
        b1.l_req = 1'b1; b1.l_we = 1'b0; b1.l_addr = 32'h60;
        #1;
        chk1("fl_rd_gnt", b1.l_gnt, 1'b1);
        repeat (3) cyc;
        #1;
        chk1("fl_rd_done", b1.l_done, 1'b1);
        chk32("fl_rd_l_rdata", b1.l_rdata, 32'h5A5A5A5A);
        b1.l_req = 1'b0;
        cyc;
        #1;
        chk1("fl_rd_done_after", b1.l_done, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencer and arbiter for the single-port data memory behind the MIPS MEM stage. Shares the memory between two requesters: the pipeline's MEM stage (load/store) and a program/debug loader port. Inserts the configured number of memory wait states, stalls the pipeline while a MEM access is outstanding, and returns read data to the winning requester.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `WAIT_STATES`, default 1: extra memory cycles per access; legal range 0..7.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `p_read`  in  1  MEM stage load request; held until `p_stall` is low.
- `p_write`  in  1  MEM stage store request; same hold rule. If both `p_read` and `p_write` are high, the access is a write.
- `p_addr`  in  ADDR_W  MEM stage address (ALU result).
- `p_wdata`  in  DATA_W  MEM stage store data.
- `p_rdata`  out  DATA_W  load data; valid in the cycle `p_stall` falls.
- `p_stall`  out  1  pipeline hold.
- `l_req`  in  1  loader request; held until `l_done`.
- `l_we`  in  1  loader write enable.
- `l_addr`  in  ADDR_W  loader address.
- `l_wdata`  in  DATA_W  loader write data.
- `l_gnt`  out  1  one-cycle pulse when the loader request is accepted.
- `l_done`  out  1  one-cycle completion pulse.
- `l_rdata`  out  DATA_W  loader read data; valid from `l_done` until the next loader completion.
- `m_read`  out  1  memory read strobe.
- `m_write`  out  1  memory write strobe.
- `m_addr`  out  ADDR_W  memory address.
- `m_wdata`  out  DATA_W  memory write data.
- `m_rdata`  in  DATA_W  memory read data; valid in the last ACCESS cycle.

## Operation
- FSM states:
  - IDLE: no access in flight.
  - ACCESS: memory strobes driven; lasts WAIT_STATES+1 cycles.
  - RESP: one cycle; result delivered.
- IDLE: if any request is present, arbitrate. Register the winner id, address, write data and direction into the access registers, then go to ACCESS. With no request, stay in IDLE.
- Arbitration is fixed priority: pipeline over loader.
- ACCESS:
  - `m_*` are driven only from the access registers and are stable for the whole state.
  - A down-counter is loaded with WAIT_STATES on entry. When it reaches 0, `m_rdata` is captured into the winner's read register and the FSM goes to RESP.
- RESP: strobes are low.
  - Pipeline winner: `p_stall` = 0 and `p_rdata` is valid.
  - Loader winner: `l_done` = 1.
  - Next state is IDLE.
- `p_stall` = (`p_read` | `p_write`) & ~(state==RESP & winner==pipeline). It is combinational from the request, so it is high in the cycle the request first appears.
- Request dropped after grant (flush): the access still completes, the memory write commits, and the result is discarded. No stall is asserted once the request is gone.
- Loader `l_req` dropped before grant: no access, no `l_done`.
- `rst` in any state: next cycle the FSM is in IDLE and all outputs are 0. An interrupted access is lost; the loader must re-request.

## Timing
- Reset values: `p_rdata`, `l_rdata`, `m_addr`, `m_wdata` = 0; `p_stall`, `l_gnt`, `l_done`, `m_read`, `m_write` = 0; state IDLE; counter 0.
- Pipeline access with the request appearing at cycle 0 (FSM idle), W = WAIT_STATES:
  - ACCESS occupies cycles 1..W+1.
  - RESP is cycle W+2.
  - `p_stall` is high for cycles 0..W+1 (W+2 cycles) and low at W+2.
- Loader access: `l_gnt` at cycle 0, `l_done` at cycle W+2.
- Throughput: one access per W+3 cycles. Back-to-back requests re-arbitrate in IDLE.
- A request arriving during ACCESS or RESP waits for IDLE. The pipeline stalls throughout that wait.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN` defined:
  - A last-served flag (reset value: loader) decides simultaneous requests in IDLE. The requester not served last wins.
  - The flag updates on every grant.
  - This bounds loader wait to one pipeline access.
- Undefined: fixed priority, pipeline always wins; no flag register.

## Structure
- Shared package `mips_dmem_pkg` holds:
  - the state enum (IDLE/ACCESS/RESP);
  - the requester id type (REQ_PIPE/REQ_LOAD);
  - the `WAIT_STATES` counter width constant (3 bits).
- Sub-module `dmem_grant` contains:
  - the combinational winner select;
  - the round-robin flag under the macro.
- Everything else (FSM, counter, access and read registers) lives in `dmem_arbiter`.

## Test plan
- **Pipeline load, W=1:** `p_read`=1, `p_addr`=32'h00230000, memory returns 32'h002300AA. Required: `p_stall` high for 3 cycles; `m_read` high for 2 cycles; `p_rdata`=32'h002300AA in the cycle stall falls.
- **Loader write then pipeline read:** loader writes 32'h8C123456 to 32'hA42ADFB0 (`l_gnt` at c0, `l_done` at c3); pipeline then loads 32'hA42ADFB0. Required: `p_rdata`=32'h8C123456.
- **Simultaneous `p_write` and `l_req` at IDLE, macro off:** pipeline is served first; `l_gnt` fires at the IDLE cycle after pipeline RESP. Repeat with the macro on, starting from the reset state (last-served = loader): the pipeline still wins first; on a second simultaneous request the loader wins.
- **`rst` asserted in the second ACCESS cycle, W=3:** next cycle `m_read`=`m_write`=0, `p_stall` depends only on the request, no `l_done`. A re-issued load completes normally.
- **W=0 edge case:** ACCESS lasts 1 cycle; `p_stall` high for exactly 2 cycles; four back-to-back pipeline stores to distinct addresses each read back correctly.
- **Flush:** `p_write` dropped during ACCESS. Required: `m_write` still completes the full ACCESS window, data is written, and `p_stall` is 0 from the cycle of the drop.
